data_mem_ctrl: RTL
==================

# data_mem_ctrl

Parametrised data-memory controller for the MIPS core. It is the successor to the fixed single-cycle word-only data RAM: configurable depth and wait states, byte/halfword/word access with sign or zero extension, and a req/ready handshake with a stall output that freezes the CPU's PC and register-file writes until the access completes. It sits between the core's ALU result and store-data paths and the load-writeback mux. The instruction ROM is unaffected.

## Interface
- `DEPTH_WORDS`, default 256: number of 32-bit words; power of 2, range 4–65536.
- `WAIT_STATES`, default 2: extra cycles per access, range 0–15.
- `ADDR_W`, default 32: byte-address width.
- `CLK` in 1: sole clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high; sampled on the `CLK` rising edge; has priority over every other input.
- `req` in 1: access request; held high by the CPU until `ready` is seen.
- `we` in 1: 1 = store, 0 = load.
- `size` in 2: access size. 00 = byte, 01 = halfword, 10 = word, 11 = treated as word.
- `sign_ext` in 1: loads only. 1 = sign-extend (lb/lh), 0 = zero-extend (lbu/lhu).
- `addr` in ADDR_W: byte address.
- `wdata` in 32: store data; byte/half taken from the low bits.
- `rdata` out 32: load result, registered.
- `ready` out 1: one-cycle completion pulse.
- `stall` out 1: CPU hold.
- `err` out 1: access-fault pulse, coincident with `ready`.

## Operation
- **FSM states:** IDLE, WAIT, DONE.
- **IDLE:**
  - With `req`=1, latch `we`, `size`, `sign_ext`, `addr`, `wdata`.
  - If `WAIT_STATES`=0, perform the access at this edge and go to DONE.
  - Otherwise clear the counter and go to WAIT.
- **WAIT:**
  - Counter increments each cycle.
  - When counter = `WAIT_STATES`-1, perform the access at that edge and go to DONE.
- **DONE:**
  - `ready`=1 for exactly one cycle, then return to IDLE.
  - `req` is ignored in DONE; it is still high from the completing instruction.
- **stall:** combinational, `(state==IDLE & req) | state==WAIT`. It is 0 in DONE.
- **Word index:** `addr[log2(DEPTH_WORDS)+1:2]`. Byte lane order is little-endian, so `addr[1:0]`=0 selects bits 7:0.
- **Stores:**
  - byte writes lane `addr[1:0]`;
  - halfword writes lanes {`addr[1]`,0} and {`addr[1]`,1};
  - word writes all four lanes;
  - unselected lanes are preserved.
- **Loads:**
  - The selected lane(s) are right-justified, then extended per `sign_ext`; word ignores `sign_ext`.
  - The result is registered into `rdata` at the access edge.
  - Stores leave `rdata` unchanged.
- **Misalignment** (half with `addr[0]`=1, word with `addr[1:0]`≠0): handling depends on configuration (see below).
- **Reset:**
  - Next state is IDLE; counter, `rdata`, `ready`, `err` are set to 0.
  - A store whose access edge has not yet occurred is discarded.
  - Memory contents are not cleared.

## Timing
- Request accepted in cycle T.
- Access edge at the end of cycle T+`WAIT_STATES`.
- `ready`/`err`/`rdata` valid in cycle T+`WAIT_STATES`+1.
- `stall` is high for cycles T through T+`WAIT_STATES` (`WAIT_STATES`+1 cycles).
- Back-to-back accesses: the next `req` is acceptable in the cycle after DONE, so throughput is one access per `WAIT_STATES`+2 cycles.
- Reset values: `rdata`=0, `ready`=0, `err`=0, `stall` = `req` (the FSM is in IDLE).
- A mid-operation `reset` takes effect at the sampling edge. `stall` follows `req` in the next cycle.

## Configuration
- **Macro:** `DMEM_FAULT_CHECK_EN`.
- **Defined:**
  - A misaligned access, or one whose word index is ≥ `DEPTH_WORDS` (address above `4*DEPTH_WORDS`-1), is a fault.
  - A fault performs no write and sets `rdata`=0.
  - `err`=1 alongside `ready` in DONE.
- **Undefined:**
  - `err` is tied to 0.
  - Misaligned addresses are aligned down (half clears `addr[0]`; word clears `addr[1:0]`).
  - Upper address bits are ignored, so the index wraps modulo `DEPTH_WORDS`.

## Test plan
- **Word store and load, `WAIT_STATES`=2:**
  - Store 0xDEADBEEF at 0x10: `stall` high 3 cycles, `ready` at T+3.
  - Load from 0x10: `rdata`=0xDEADBEEF at T+3, `err`=0.
- **Byte and half lanes:**
  - Store byte 0x80 to 0x11 over word 0x00000000 → word reads 0x00008000.
  - lb 0x11 → 0xFFFFFF80; lbu 0x11 → 0x00000080.
  - Store half 0x1234 to 0x12 → word reads 0x12348000; lh 0x12 → 0x00001234.
- **`WAIT_STATES`=0:** `req` at T gives `stall`=1 only in T and `ready` at T+1. Three back-to-back loads complete every 2 cycles.
- **Reset mid-operation:**
  - Store 0x55 to 0x20 with `reset` asserted at T+1, `WAIT_STATES`=3.
  - Word 0x20 keeps its prior value, `ready` never pulses, and the FSM is IDLE at T+2.
- **Fault with the macro defined, `DEPTH_WORDS`=256:**
  - Word load 0x402 → `err`=1, `rdata`=0.
  - Store to 0x400 → `err`=1, memory unchanged.
- **Macro undefined:**
  - Word store 0xA5A5A5A5 to 0x402 lands at word 0; a load from 0x0 returns it.
  - `err` stays 0 throughout.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl -- data-memory controller for the MIPS core.
//
// A word-organised RAM sits behind a req/ready handshake. Each access takes
// WAIT_STATES extra cycles. Loads and stores can be byte, halfword or word
// wide, and loads are sign- or zero-extended. While an access is in flight,
// stall holds the CPU's PC and register-file writes.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of 2, 4..65536)
//   WAIT_STATES  extra cycles per access (0..15)
//   ADDR_W       byte-address width (must be >= log2(DEPTH_WORDS)+2)
//
// Ports:
//   CLK       sole clock, rising edge
//   reset     synchronous active-high reset, highest priority
//   req       access request, held by the CPU until ready
//   we        1 = store, 0 = load
//   size      00 byte, 01 halfword, 10/11 word
//   sign_ext  loads only: 1 = sign-extend, 0 = zero-extend
//   addr      byte address
//   wdata     store data (byte/half taken from the low bits)
//   rdata     registered load result
//   ready     one-cycle completion pulse
//   stall     CPU hold (combinational)
//   err       access-fault pulse, coincident with ready
//
// Build option:
//   DMEM_FAULT_CHECK_EN  when defined, misaligned or out-of-range accesses
//                        fault (no write, rdata=0, err=1). Otherwise they are
//                        aligned down and the word index wraps, and err stays 0.

module data_mem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              stall,
  output logic              err
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAST_CNT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

`ifdef DMEM_FAULT_CHECK_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t state, next_state;
  logic [3:0] cnt;
  logic       access;

  // Request fields captured at acceptance.
  logic              we_q;
  logic [1:0]        size_q;
  logic              sx_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  // Active access fields. With WAIT_STATES=0 the access happens on the
  // accepting edge itself, so the live inputs must be used in IDLE.
  logic              a_we;
  logic [1:0]        a_size;
  logic              a_sx;
  logic [ADDR_W-1:0] a_addr;
  logic [31:0]       a_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  logic [IDX_W-1:0]  idx;
  logic [ADDR_W-1:0] addr_hi;
  logic              out_of_range;
  logic              misaligned;
  logic              fault;
  logic [31:0]       rword;
  logic [7:0]        rbyte;
  logic [15:0]       rhalf;
  logic [31:0]       load_val;
  logic [3:0]        be;
  logic [31:0]       wlanes;

  always_comb begin
    if (state == IDLE) begin
      a_we    = we;
      a_size  = size;
      a_sx    = sign_ext;
      a_addr  = addr;
      a_wdata = wdata;
    end else begin
      a_we    = we_q;
      a_size  = size_q;
      a_sx    = sx_q;
      a_addr  = addr_q;
      a_wdata = wdata_q;
    end
  end

  // Next-state logic. The access strobe marks the edge that touches memory.
  always_comb begin
    next_state = state;
    access     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            access     = 1'b1;
            next_state = DONE;
          end else begin
            next_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == LAST_CNT) begin
          access     = 1'b1;
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign stall = ((state == IDLE) && req) || (state == WAIT);

  // Address decode. Index bits above the word index are ignored (wrap)
  // unless fault checking is enabled.
  assign idx          = a_addr[IDX_W+1:2];
  assign addr_hi      = a_addr >> (IDX_W + 2);
  assign out_of_range = |addr_hi;
  assign misaligned   = ((a_size == 2'b01) && a_addr[0]) ||
                        (a_size[1] && (a_addr[1:0] != 2'b00));
  assign fault        = FAULT_EN && (misaligned || out_of_range);

  // Load path. Halfword and word selection ignore the low address bits,
  // which performs the align-down when faults are not checked.
  assign rword = mem[idx];

  always_comb begin
    case (a_addr[1:0])
      2'd0:    rbyte = rword[7:0];
      2'd1:    rbyte = rword[15:8];
      2'd2:    rbyte = rword[23:16];
      default: rbyte = rword[31:24];
    endcase
    rhalf = a_addr[1] ? rword[31:16] : rword[15:0];
    case (a_size)
      2'b00:   load_val = {{24{a_sx & rbyte[7]}}, rbyte};
      2'b01:   load_val = {{16{a_sx & rhalf[15]}}, rhalf};
      default: load_val = rword;
    endcase
  end

  // Store path. The data is replicated across lanes so each enabled lane
  // picks up the right bits.
  always_comb begin
    case (a_size)
      2'b00: begin
        be     = 4'b0001 << a_addr[1:0];
        wlanes = {4{a_wdata[7:0]}};
      end
      2'b01: begin
        be     = a_addr[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{a_wdata[15:0]}};
      end
      default: begin
        be     = 4'b1111;
        wlanes = a_wdata;
      end
    endcase
  end

  // Memory contents survive reset. A store whose edge coincides with reset
  // is dropped.
  always_ff @(posedge CLK) begin
    if (!reset && access && a_we && !fault) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if ((state == IDLE) && req) begin
      we_q    <= we;
      size_q  <= size;
      sx_q    <= sign_ext;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      rdata <= '0;
      ready <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= next_state;
      ready <= access;
      err   <= access && fault;
      if ((state == IDLE) && req) begin
        cnt <= '0;
      end else if (state == WAIT) begin
        cnt <= cnt + 4'd1;
      end
      if (access) begin
        if (fault) begin
          rdata <= '0;
        end else if (!a_we) begin
          rdata <= load_val;
        end
      end
    end
  end

endmodule
